// File: rtl/pointer_reg_bank_if.sv
// Bus-side signal bundle for pointer_reg_bank: write port, rewind/increment
// requests and the pointer/status outputs.
interface pointer_reg_bank_if #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned SEL_W    = 1
);
  logic                      Wen;
  logic [SEL_W-1:0]          Sel;
  logic [1:0]                WMode;
  logic [WIDTH-1:0]          BusOut;
  logic [CHANNELS-1:0]       Rew;
  logic [CHANNELS-1:0]       Inc;
  logic [CHANNELS*WIDTH-1:0] Dout;
  logic [CHANNELS-1:0]       AtLimit;
  logic [CHANNELS-1:0]       Wrap;

  // Requester side: drives writes and per-channel ops, observes pointers.
  modport master (
    output Wen, Sel, WMode, BusOut, Rew, Inc,
    input  Dout, AtLimit, Wrap
  );

  // Register bank side.
  modport slave (
    input  Wen, Sel, WMode, BusOut, Rew, Inc,
    output Dout, AtLimit, Wrap
  );
endinterface

// File: rtl/pointer_reg_bank.sv
// Bank of pointer channels, each with base and limit registers. Pointers load
// from the bus, rewind to base, or increment with wrap from limit to base. With
// CHAIN set, a wrap on channel i carries an increment into channel i+1 in the
// same cycle (the carry ripples combinationally through the whole bank).
module pointer_reg_bank #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned SEL_W    = 1,
  parameter int unsigned CHAIN    = 1
) (
  input logic               Clk,
  input logic               RST,
  pointer_reg_bank_if.slave bus
);

  localparam logic [1:0] WmPtr     = 2'd0;
  localparam logic [1:0] WmPtrBase = 2'd1;
  localparam logic [1:0] WmLim     = 2'd2;
  localparam logic [1:0] WmNone    = 2'd3;

  logic [WIDTH-1:0]    ptr_q  [CHANNELS];
  logic [WIDTH-1:0]    ptr_d  [CHANNELS];
  logic [WIDTH-1:0]    base_q [CHANNELS];
  logic [WIDTH-1:0]    base_d [CHANNELS];
  logic [WIDTH-1:0]    lim_q  [CHANNELS];
  logic [WIDTH-1:0]    lim_d  [CHANNELS];
  logic [CHANNELS-1:0] wrap_q;
  logic [CHANNELS-1:0] carry;

  logic chain_en;
  assign chain_en = (CHAIN != 0);

  // Write decode, carry ripple and per-channel next-state selection.
  always_comb begin
    logic carry_prev;
    logic wr;
    logic wr_ptr;
    logic inc_eff;
    logic at_lim;
    carry_prev = 1'b0;
    carry      = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      ptr_d[i]  = ptr_q[i];
      base_d[i] = base_q[i];
      lim_d[i]  = lim_q[i];

      // Out-of-range selects never match any channel, so they are dropped.
      wr      = bus.Wen && (32'(bus.Sel) == i) && (bus.WMode != WmNone);
      wr_ptr  = wr && ((bus.WMode == WmPtr) || (bus.WMode == WmPtrBase));
      // Own request and chained carry merge into a single increment.
      inc_eff = bus.Inc[i] | (chain_en & carry_prev);
      at_lim  = (ptr_q[i] == lim_q[i]);

      carry[i]   = inc_eff & at_lim & ~wr_ptr & ~bus.Rew[i];
      carry_prev = carry[i];

      if (wr_ptr) begin
        ptr_d[i] = bus.BusOut;
        if (bus.WMode == WmPtrBase) begin
          base_d[i] = bus.BusOut;
        end
      end else begin
        // A limit write leaves the pointer path open; compare uses the old limit.
        if (wr && (bus.WMode == WmLim)) begin
          lim_d[i] = bus.BusOut;
        end
        if (bus.Rew[i]) begin
          ptr_d[i] = base_q[i];
        end else if (inc_eff) begin
          ptr_d[i] = at_lim ? base_q[i] : ptr_q[i] + WIDTH'(1);
        end
      end
    end
  end

  // State registers with asynchronous reset to the power-on pointer window.
  always_ff @(posedge Clk or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < CHANNELS; i++) begin
        ptr_q[i]  <= '0;
        base_q[i] <= '0;
        lim_q[i]  <= '1;
      end
      wrap_q <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        ptr_q[i]  <= ptr_d[i];
        base_q[i] <= base_d[i];
        lim_q[i]  <= lim_d[i];
      end
      wrap_q <= carry;
    end
  end

  // Outputs come straight from the registers.
  always_comb begin
    bus.Dout    = '0;
    bus.AtLimit = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      bus.Dout[i*WIDTH +: WIDTH] = ptr_q[i];
      bus.AtLimit[i]             = (ptr_q[i] == lim_q[i]);
    end
    bus.Wrap = wrap_q;
  end

endmodule
